// File: rtl/config_stream_loader.sv
// Configuration bitstream loader: validates a {MAGIC, N} header, then issues N single-cycle
// writes on the shared tile configuration bus, one per addr/data word pair.
module config_stream_loader #(
  parameter logic [15:0] MAGIC       = 16'hC0F1,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] write_count
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StHeader = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StWrite  = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;
  localparam logic [2:0] StError  = 3'd6;

  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      count_q, count_d;
  logic [31:0]      cfg_addr_q, cfg_addr_d;
  logic [31:0]      cfg_data_q, cfg_data_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             xfer;

  // in_ready_q is high exactly in HEADER/ADDR/DATA, so it doubles as the loading flag.
  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wdog_d      = wdog_q;
    addr_d      = addr_q;
    count_d     = count_q;
    cfg_addr_d  = IDLE_ADDR;
    cfg_data_d  = 32'h0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d = StHeader;
          count_d = 16'h0;
        end
      end
      StHeader: begin
        if (xfer) begin
          if (in_data[31:16] != MAGIC) begin
            state_d = StError;
          end else if (in_data[15:0] == 16'h0) begin
            state_d = StDone;
          end else begin
            remaining_d = in_data[15:0];
            state_d     = StAddr;
          end
        end
      end
      StAddr: begin
        if (xfer) begin
          if (in_data[31:16] == 16'h0) begin
            state_d = StError;
          end else begin
            addr_d  = in_data;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          cfg_addr_d = addr_q;
          cfg_data_d = in_data;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        count_d     = count_q + 16'd1;
        remaining_d = remaining_q - 16'd1;
        state_d     = (remaining_q == 16'd1) ? StDone : StAddr;
      end
      default: state_d = StIdle;
    endcase

    // Watchdog only runs while waiting on the stream.
    if (in_ready_q) begin
      if (xfer) begin
        wdog_d = '0;
      end else if (wdog_q == WdogLast) begin
        state_d = StError;
      end else begin
        wdog_d = wdog_q + WdogW'(1);
      end
    end
    if (state_d != state_q) wdog_d = '0;

    in_ready_d = (state_d == StHeader) || (state_d == StAddr) || (state_d == StData);
    busy_d     = in_ready_d || (state_d == StWrite);
    done_d     = (state_d == StDone);
    error_d    = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= 16'h0;
      wdog_q      <= '0;
      addr_q      <= 32'h0;
      count_q     <= 16'h0;
      cfg_addr_q  <= IDLE_ADDR;
      cfg_data_q  <= 32'h0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wdog_q      <= wdog_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign config_addr = cfg_addr_q;
  assign config_data = cfg_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign write_count = count_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: a transaction-level monitor checks every bus write
// against the pairs the stimulus sent, plus hand-computed checks of flags and timing.
module tb_config_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] write_count;

  config_stream_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .config_addr (config_addr),
    .config_data (config_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];    // {addr, data} pairs the bus must still show, in order
  int          wr_cyc[$];   // cycle stamps of observed writes
  int          cyc = 0;
  int          obs_cnt = 0; // writes observed since last start/reset
  logic        pend = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: bus writes must match the sent pairs; count, bus and flag rules every cycle.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset || start) obs_cnt = 0;
      else if (pend) obs_cnt++;
      pend = 1'b0;
      @(negedge clk);
      if (mon_en) begin
        check("write_count_tracks", {16'h0, write_count}, obs_cnt);
        check("flags_onehot0", {31'h0, $onehot0({busy, done, error})}, 32'd1);
        check("ready_implies_busy", {31'h0, !in_ready || busy}, 32'd1);
        if (config_addr != 32'h0) begin
          check("no_back_to_back", prev_addr, 32'h0);
          check("ready_low_in_write", {31'h0, in_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_write", config_addr, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", config_addr, e[63:32]);
            check("wr_data", config_data, e[31:0]);
          end
          pend = 1'b1;
          wr_cyc.push_back(cyc);
        end else begin
          check("idle_data_zero", config_data, 32'h0);
        end
        prev_addr = config_addr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1);
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send(input logic [31:0] w);
    int   n;
    logic r;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 2000);
    if (!r) check("handshake_timeout", {31'h0, r}, 32'd1);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("rst_addr", config_addr, 32'h0);
    check("rst_data", config_data, 32'h0);
    check("rst_flags", {29'h0, busy, done, error}, 32'd0);
    check("rst_count", {16'h0, write_count}, 32'd0);
    resync();
    reset = 1'b0;
    mon_en = 1'b1;

    // 1) two pairs
    do_start();
    send(32'hC0F1_0002);
    exp_q.push_back({32'h0006_0003, 32'h0000_0005});
    send(32'h0006_0003);
    send(32'h0000_0005);
    exp_q.push_back({32'h0004_0003, 32'h0000_0002});
    send(32'h0004_0003);
    send(32'h0000_0002);
    idle(3);
    @(negedge clk);
    check("t1_done", {31'h0, done}, 32'd1);
    check("t1_count", {16'h0, write_count}, 32'd2);
    check("t1_all_written", exp_q.size(), 32'd0);
    resync();

    // 2) bad magic
    do_start();
    send(32'hBEEF_0001);
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_error", {31'h0, error}, 32'd1);
    check("t2_ready", {31'h0, in_ready}, 32'd0);
    check("t2_busy", {31'h0, busy}, 32'd0);
    resync();
    do_start();
    @(negedge clk);
    check("t2_error_cleared", {31'h0, error}, 32'd0);
    check("t2_busy_after_start", {31'h0, busy}, 32'd1);
    resync();

    // 3) empty load
    send(32'hC0F1_0000);
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_done", {31'h0, done}, 32'd1);
    check("t3_bus_idle", config_addr, 32'h0);
    check("t3_count", {16'h0, write_count}, 32'd0);
    resync();

    // 4) watchdog in DATA
    do_start();
    send(32'hC0F1_0001);
    send(32'h0005_0001);
    in_valid = 1'b0;
    repeat (1023) @(posedge clk);
    @(negedge clk);
    check("t4_no_error_yet", {31'h0, error}, 32'd0);
    check("t4_still_busy", {31'h0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t4_error", {31'h0, error}, 32'd1);
    resync();
    idle(3);
    check("t4_no_write", {16'h0, write_count}, 32'd0);

    // 5a) unwritable address
    do_start();
    send(32'hC0F1_0001);
    send(32'h0000_0005);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_error", {31'h0, error}, 32'd1);
    resync();

    // 5b) reset during WRITE
    do_start();
    send(32'hC0F1_0001);
    exp_q.push_back({32'h0007_0009, 32'h0000_00AB});
    send(32'h0007_0009);
    send(32'h0000_00AB);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_write_visible", config_addr, 32'h0007_0009);
    reset = 1'b1;
    resync();
    reset = 1'b0;
    @(negedge clk);
    check("t5_bus_idle", config_addr, 32'h0);
    check("t5_flags_idle", {28'h0, in_ready, busy, done, error}, 32'd0);
    check("t5_count", {16'h0, write_count}, 32'd0);
    resync();
    idle(4);
    check("t5_no_more_writes", exp_q.size(), 32'd0);

    // 6) in_valid held high, N=3
    wr_cyc.delete();
    do_start();
    pat = '0;
    fork
      begin
        repeat (10) begin
          @(negedge clk);
          pat = {pat[8:0], in_ready};
        end
      end
      begin
        send(32'hC0F1_0003);
        exp_q.push_back({32'h0004_0001, 32'h0000_0011});
        send(32'h0004_0001);
        send(32'h0000_0011);
        exp_q.push_back({32'h0005_0002, 32'h0000_0022});
        send(32'h0005_0002);
        send(32'h0000_0022);
        exp_q.push_back({32'h0006_0003, 32'h0000_0033});
        send(32'h0006_0003);
        send(32'h0000_0033);
      end
    join
    resync();
    idle(3);
    check("t6_ready_pattern", {22'h0, pat}, 32'b11_1011_0110);
    check("t6_num_writes", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() == 3) begin
      check("t6_spacing_1", wr_cyc[1] - wr_cyc[0], 32'd3);
      check("t6_spacing_2", wr_cyc[2] - wr_cyc[1], 32'd3);
    end
    check("t6_done", {31'h0, done}, 32'd1);
    check("t6_count", {16'h0, write_count}, 32'd3);
    check("final_all_written", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
